// File: rtl/axi_ar_rr_scheduler.sv
// Round-robin AR scheduler: grants one requester at a time, holds the grant until the
// downstream handshake, and throttles each port to MAX_OUTSTANDING reads in flight.
module axi_ar_rr_scheduler #(
    parameter int N_TARG_PORT     = 7,
    parameter int LOG_N_TARG      = $clog2(N_TARG_PORT),
    parameter int MAX_OUTSTANDING = 8,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_TARG_PORT-1:0]       arvalid_i,
    output logic [N_TARG_PORT-1:0]       arready_o,
    output logic                         arvalid_o,
    input  logic                         arready_i,
    output logic [LOG_N_TARG-1:0]        grant_idx_o,
    output logic [N_TARG_PORT-1:0]       grant_oh_o,
    input  logic                         rvalid_i,
    input  logic                         rready_i,
    input  logic                         rlast_i,
    input  logic [LOG_N_TARG-1:0]        rid_src_i,
    output logic [N_TARG_PORT*CNT_W-1:0] outstanding_o,
    output logic                         err_o
);

    typedef enum logic {IDLE, GRANT} state_e;

    state_e                  state_q, state_d;
    logic [LOG_N_TARG-1:0]   ptr_q, ptr_d;
    logic [LOG_N_TARG-1:0]   grant_idx_q, grant_idx_d;
    logic [N_TARG_PORT-1:0]  grant_oh_q, grant_oh_d;
    logic [CNT_W-1:0]        cnt_q [N_TARG_PORT];
    logic [CNT_W-1:0]        cnt_d [N_TARG_PORT];
    logic                    err_q, err_d;

    logic                    ar_hs;
    logic                    r_last_hs;
    logic                    rid_valid;
    logic                    inc;
    logic                    dec;
    logic [N_TARG_PORT-1:0]  elig;
    logic                    any_elig;
    logic [LOG_N_TARG-1:0]   win_idx;
    logic [LOG_N_TARG-1:0]   p_idx;
    logic [31:0]             p;

    // Credit counters, eligibility and error detection, all from post-update counts.
    always_comb begin
        ar_hs     = (state_q == GRANT) && arready_i;
        r_last_hs = rvalid_i && rready_i && rlast_i;
        rid_valid = int'(rid_src_i) < N_TARG_PORT;
        err_d     = err_q;
        inc       = 1'b0;
        dec       = 1'b0;
        for (int unsigned i = 0; i < N_TARG_PORT; i++) begin
            inc      = ar_hs && (grant_idx_q == LOG_N_TARG'(i));
            dec      = r_last_hs && rid_valid && (rid_src_i == LOG_N_TARG'(i));
            cnt_d[i] = cnt_q[i];
            if (dec && cnt_q[i] == '0) begin
                err_d = 1'b1;
            end
            if (inc && !dec) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (dec && !inc && cnt_q[i] != '0) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
            elig[i] = arvalid_i[i] && (cnt_d[i] < CNT_W'(MAX_OUTSTANDING));
        end
        if (r_last_hs && !rid_valid) begin
            err_d = 1'b1;
        end
        if (state_q == GRANT && !arvalid_i[grant_idx_q]) begin
            err_d = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (ar_hs) begin
            ptr_d = (grant_idx_q == LOG_N_TARG'(N_TARG_PORT - 1)) ? '0
                                                                  : grant_idx_q + LOG_N_TARG'(1);
        end
    end

    // Search starts at the already-advanced pointer so back-to-back grants rotate.
    always_comb begin
        any_elig = 1'b0;
        win_idx  = '0;
        p        = '0;
        p_idx    = '0;
        for (int unsigned off = 0; off < N_TARG_PORT; off++) begin
            p = 32'(ptr_d) + off;
            if (p >= 32'(N_TARG_PORT)) begin
                p = p - 32'(N_TARG_PORT);
            end
            p_idx = LOG_N_TARG'(p);
            if (!any_elig && elig[p_idx]) begin
                any_elig = 1'b1;
                win_idx  = p_idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        grant_oh_d  = grant_oh_q;
        case (state_q)
            IDLE: begin
                if (any_elig) begin
                    state_d     = GRANT;
                    grant_idx_d = win_idx;
                    grant_oh_d  = N_TARG_PORT'(1) << win_idx;
                end
            end
            GRANT: begin
                if (ar_hs) begin
                    if (any_elig) begin
                        grant_idx_d = win_idx;
                        grant_oh_d  = N_TARG_PORT'(1) << win_idx;
                    end else begin
                        state_d    = IDLE;
                        grant_oh_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            grant_idx_q <= '0;
            grant_oh_q  <= '0;
            err_q       <= 1'b0;
            for (int unsigned i = 0; i < N_TARG_PORT; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_idx_q <= grant_idx_d;
            grant_oh_q  <= grant_oh_d;
            err_q       <= err_d;
            for (int unsigned i = 0; i < N_TARG_PORT; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        arvalid_o   = (state_q == GRANT);
        arready_o   = grant_oh_q & {N_TARG_PORT{arready_i && (state_q == GRANT)}};
        grant_idx_o = grant_idx_q;
        grant_oh_o  = grant_oh_q;
        err_o       = err_q;
        for (int unsigned i = 0; i < N_TARG_PORT; i++) begin
            outstanding_o[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end

endmodule

// File: tb/tb_axi_ar_rr_scheduler.sv
// Directed bench for axi_ar_rr_scheduler: grant latency, rotation, backpressure,
// credit limit, simultaneous credit update and error flag.
module tb_axi_ar_rr_scheduler;

    localparam int N  = 7;
    localparam int LN = 3;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  arvalid_i;
    logic [N-1:0]  arready_o;
    logic          arvalid_o;
    logic          arready_i;
    logic [LN-1:0] grant_idx_o;
    logic [N-1:0]  grant_oh_o;
    logic          rvalid_i, rready_i, rlast_i;
    logic [LN-1:0] rid_src_i;
    logic [N*CW-1:0] outstanding_o;
    logic          err_o;

    int tests = 0;
    int fails = 0;
    int hs_cnt;

    axi_ar_rr_scheduler #(
        .N_TARG_PORT(N),
        .MAX_OUTSTANDING(8)
    ) dut (
        .clk(clk), .rst(rst),
        .arvalid_i(arvalid_i), .arready_o(arready_o),
        .arvalid_o(arvalid_o), .arready_i(arready_i),
        .grant_idx_o(grant_idx_o), .grant_oh_o(grant_oh_o),
        .rvalid_i(rvalid_i), .rready_i(rready_i), .rlast_i(rlast_i),
        .rid_src_i(rid_src_i), .outstanding_o(outstanding_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] cnt(input int i);
        logic [CW-1:0] c;
        c = outstanding_o[i*CW +: CW];
        return 32'(c);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_r(input logic en, input logic [LN-1:0] id);
        rvalid_i  = en;
        rready_i  = en;
        rlast_i   = en;
        rid_src_i = id;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        arvalid_i = '0;
        arready_i = 1'b0;
        set_r(1'b0, '0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        check("rst_arvalid", 32'(arvalid_o), 0);
        check("rst_arready", 32'(arready_o), 0);
        check("rst_gidx", 32'(grant_idx_o), 0);
        check("rst_goh", 32'(grant_oh_o), 0);
        check("rst_cnt", 32'(outstanding_o), 0);
        check("rst_err", 32'(err_o), 0);

        // single request on port 3; pointer advance revealed by the next winner
        arvalid_i = 7'b0001000;
        arready_i = 1'b1;
        tick();
        check("single_arvalid", 32'(arvalid_o), 1);
        check("single_gidx", 32'(grant_idx_o), 3);
        check("single_goh", 32'(grant_oh_o), 32'h08);
        check("single_arready", 32'(arready_o), 32'h08);
        arvalid_i = 7'b1111111;
        tick();
        check("single_cnt3", cnt(3), 1);
        check("single_ptr4", 32'(grant_idx_o), 4);
        do_reset();
        check("midrst_arvalid", 32'(arvalid_o), 0);
        check("midrst_cnt", 32'(outstanding_o), 0);

        // round robin, all ports requesting
        arvalid_i = 7'b1111111;
        arready_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("rr_gidx%0d", k), 32'(grant_idx_o), 32'(k % N));
            check($sformatf("rr_arvalid%0d", k), 32'(arvalid_o), 1);
        end
        do_reset();

        // backpressure on port 2
        arvalid_i = 7'b0000100;
        arready_i = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            check("bp_gidx", 32'(grant_idx_o), 2);
            check("bp_arvalid", 32'(arvalid_o), 1);
            check("bp_arready", 32'(arready_o), 0);
            check("bp_cnt2", cnt(2), 0);
            tick();
        end
        arready_i = 1'b1;
        #1;
        check("bp_arready_on", 32'(arready_o), 32'h04);
        tick();
        check("bp_cnt2_after", cnt(2), 1);
        do_reset();

        // credit limit on port 1
        arvalid_i = 7'b0000010;
        arready_i = 1'b1;
        tick();
        hs_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            if (arvalid_o && arready_o[1]) hs_cnt++;
            tick();
        end
        check("lim_hs", 32'(hs_cnt), 8);
        check("lim_cnt1", cnt(1), 8);
        check("lim_arvalid", 32'(arvalid_o), 0);
        set_r(1'b1, 3'd1);
        tick();
        set_r(1'b0, '0);
        check("lim_cnt1_free", cnt(1), 7);
        check("lim_arvalid_again", 32'(arvalid_o), 1);
        check("lim_gidx", 32'(grant_idx_o), 1);
        check("lim_err", 32'(err_o), 0);
        do_reset();

        // simultaneous increment and decrement on port 4
        arvalid_i = 7'b0010000;
        arready_i = 1'b1;
        tick();
        tick();
        tick();
        tick();
        check("sim_cnt4_pre", cnt(4), 3);
        arready_i = 1'b0;
        set_r(1'b1, 3'd4);
        #1;
        arready_i = 1'b1;
        tick();
        set_r(1'b0, '0);
        check("sim_cnt4", cnt(4), 3);
        check("sim_err", 32'(err_o), 0);
        do_reset();

        // decrement at zero
        set_r(1'b1, 3'd5);
        tick();
        set_r(1'b0, '0);
        check("err0_cnt5", cnt(5), 0);
        check("err0_flag", 32'(err_o), 1);
        tick();
        check("err0_sticky", 32'(err_o), 1);
        do_reset();
        check("err_rst_clear", 32'(err_o), 0);

        // out-of-range source id
        set_r(1'b1, 3'd7);
        tick();
        set_r(1'b0, '0);
        check("err7_flag", 32'(err_o), 1);
        check("err7_cnt", 32'(outstanding_o), 0);
        do_reset();

        // requester drops valid while granted
        arvalid_i = 7'b0000001;
        arready_i = 1'b0;
        tick();
        check("drop_pre_err", 32'(err_o), 0);
        arvalid_i = '0;
        tick();
        check("drop_err", 32'(err_o), 1);
        check("drop_gidx", 32'(grant_idx_o), 0);
        check("drop_arvalid", 32'(arvalid_o), 1);
        check("drop_goh", 32'(grant_oh_o), 32'h01);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axi_ar_rr_scheduler.md
# axi_ar_rr_scheduler

Read-address scheduler that sits in front of the AR payload mux of an AXI node master port. It grants one of N_TARG_PORT requesters at a time using round-robin arbitration and holds each grant stable until the downstream handshake completes. It throttles every requester to MAX_OUTSTANDING in-flight reads, freeing credits when R last-beats return. It drives the mux select, so the payload datapath stays purely combinational.

## Interface
- N_TARG_PORT, 7: number of requesting slave ports.
- LOG_N_TARG, $clog2(N_TARG_PORT): width of the port index.
- MAX_OUTSTANDING, 8: maximum in-flight reads per port.
- CNT_W, $clog2(MAX_OUTSTANDING+1): width of each credit counter.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- arvalid_i  in  N_TARG_PORT  per-port AR valid.
- arready_o  out  N_TARG_PORT  per-port AR ready.
- arvalid_o  out  1  AR valid towards the slave side.
- arready_i  in  1  AR ready from the slave side.
- grant_idx_o  out  LOG_N_TARG  binary index of the granted port; drives the payload mux and the ID prefix.
- grant_oh_o  out  N_TARG_PORT  one-hot grant; all zero when idle.
- rvalid_i, rready_i, rlast_i  in  1 each  observed R channel handshake.
- rid_src_i  in  LOG_N_TARG  upper R ID bits, i.e. the issuing port index.
- outstanding_o  out  N_TARG_PORT*CNT_W  per-port credit counters, packed with port 0 in the LSBs.
- err_o  out  1  sticky protocol error flag.

## Operation
- State machine: IDLE and GRANT.
- Counters: one cnt[i] per port.
  - Increment on AR handshake of port i: arvalid_o & arready_i & grant_idx_o==i.
  - Decrement on rvalid_i & rready_i & rlast_i & rid_src_i==i.
  - If both happen in the same cycle on the same port, cnt[i] is unchanged.
  - cnt_nxt[i] is the post-update value.
- Eligibility: elig[i] = arvalid_i[i] & (cnt_nxt[i] < MAX_OUTSTANDING).
- Round-robin:
  - Search elig starting at ptr, wrapping modulo N_TARG_PORT; the first hit wins.
  - After each AR handshake on port g, ptr is set to g+1. When g = N_TARG_PORT-1, ptr wraps to 0.
- IDLE:
  - If any elig bit is set, register the winner into grant_idx_o and grant_oh_o and go to GRANT.
  - Otherwise stay in IDLE.
- GRANT:
  - arvalid_o=1.
  - arready_o[grant_idx_o]=arready_i combinationally; all other arready_o bits are 0.
  - Without a handshake, hold the grant. It does not change even if arvalid_i[grant] drops; that case also sets err_o.
  - On a handshake, re-arbitrate in the same cycle using cnt_nxt and the updated ptr. If any port is eligible, load the new winner and stay in GRANT. Otherwise go to IDLE.
- Error conditions: err_o sets on any of the following, and clears only on rst.
  - A decrement when cnt is 0; the counter saturates at 0.
  - rid_src_i >= N_TARG_PORT on an R last-beat handshake; the event is otherwise ignored.
  - arvalid_i of the granted port low during GRANT.
- Counters never exceed MAX_OUTSTANDING, because eligibility blocks the issue.

## Timing
- Reset values:
  - State IDLE; ptr=0.
  - arvalid_o=0, arready_o=0, grant_idx_o=0, grant_oh_o=0.
  - All counters 0; err_o=0.
- Latency: arvalid_i rising in IDLE at cycle t gives arvalid_o=1 at t+1, with grant_idx_o registered and stable.
- Throughput: one AR per cycle while requests are eligible. Handshake at t leads to the next grant valid at t+1, and arvalid_o stays high with no bubble.
- arvalid_o, grant_idx_o and grant_oh_o are register outputs. arready_o is combinational from arready_i.
- A credit freed by an R last-beat at cycle t can make its port eligible for a grant registered at the end of t, so arvalid_o for it can be high at t+1.
- Reset mid-transaction: state returns to IDLE and counters clear. In-flight R beats after reset raise err_o through the decrement-at-zero rule.

## Test plan
- Single request: ports 0..6 idle; arvalid_i[3]=1 at cycle 2; arready_i=1 -> arvalid_o=1 and grant_idx_o=3 at cycle 3, arready_o=7'b0001000, then cnt[3]=1 and ptr=4.
- Round-robin fairness: all 7 ports hold arvalid_i=1 and arready_i=1 -> grant sequence 0,1,2,3,4,5,6,0 on consecutive cycles with arvalid_o continuously high.
- Backpressure: grant on port 2, arready_i=0 for 5 cycles -> grant_idx_o stays 2, arvalid_o=1, arready_o=0 throughout, and cnt[2] is unchanged until ready.
- Credit limit: port 1 alone requesting, no R returns -> exactly 8 handshakes, then arvalid_o=0 with cnt[1]=8. One R last-beat with rid_src_i=1 -> cnt[1]=7, and arvalid_o=1 on the next cycle.
- Simultaneous inc and dec: cnt[4]=3, then an AR handshake on port 4 and an R last-beat with rid_src_i=4 in the same cycle -> cnt[4]=3.
- Errors: R last-beat on port 5 with cnt[5]=0 -> cnt[5]=0 and err_o=1 from the next cycle. Separately, rid_src_i=7 -> err_o=1 and no counter changes.
